// File: rtl/pwm_deadtime_gate_pkg.sv
// Shared definitions for the inverter gate-drive path: per-leg state encoding,
// switch-pattern bit positions and the request-to-state decode.
package bldc_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    H_ON = 2'd1,
    L_ON = 2'd2,
    DEAD = 2'd3
  } leg_state_t;

  localparam int unsigned AH = 5;
  localparam int unsigned AL = 4;
  localparam int unsigned BH = 3;
  localparam int unsigned BL = 2;
  localparam int unsigned CH = 1;
  localparam int unsigned CL = 0;

  localparam int unsigned N_LEGS = 3;

  // Conflicting or absent requests both resolve to "nothing conducts".
  function automatic leg_state_t target_state(input logic req_h, input logic req_l);
    if (req_h && !req_l) begin
      return H_ON;
    end else if (req_l && !req_h) begin
      return L_ON;
    end
    return OFF;
  endfunction

endpackage

// File: rtl/pwm_deadtime_gate_if.sv
// Control/status bundle between commutation logic and the gate-drive stage.
interface pwm_deadtime_gate_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DT_W  = 6
);
  logic             en;
  logic [CNT_W-1:0] duty;
  logic [DT_W-1:0]  dead;
  logic [5:0]       PT;
  logic             clr_flt;
  logic [5:0]       G;
  logic             pwm_sync;
  logic             flt;

  modport master (
    output en, duty, dead, PT, clr_flt,
    input  G, pwm_sync, flt
  );

  modport slave (
    input  en, duty, dead, PT, clr_flt,
    output G, pwm_sync, flt
  );
endinterface

// File: rtl/pwm_deadtime_gate_deadtime_leg.sv
// One inverter leg: break-before-make sequencing with a programmable dead time
// between any conducting switch turning off and the next switch turning on.
module deadtime_leg
  import bldc_pkg::*;
#(
  parameter int unsigned DT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            reqH,
  input  logic            reqL,
  input  logic [DT_W-1:0] dead,
  output logic            gH,
  output logic            gL,
  output logic            viol
);

  leg_state_t      state, state_n, tgt;
  logic [DT_W-1:0] dcnt, dcnt_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OFF;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    dcnt_n  = dcnt;
    tgt     = target_state(reqH, reqL);
    viol    = reqH & reqL;
    case (state)
      OFF: state_n = tgt;
      H_ON, L_ON: begin
        if (tgt != state) begin
          state_n = DEAD;
          dcnt_n  = dead;
        end
      end
      // The gap always runs to completion, even if the same switch is re-requested.
      DEAD: begin
        if (dcnt != '0) begin
          dcnt_n = dcnt - 1'b1;
        end else begin
          state_n = tgt;
        end
      end
      default: state_n = OFF;
    endcase
  end

  assign gH = (state == H_ON);
  assign gL = (state == L_ON);

  a_leg_exclusive: assert property (@(posedge clk) disable iff (rst) !(gH && gL));

  a_dead_entry: assert property (@(posedge clk) disable iff (rst)
    ((state == H_ON || state == L_ON) && state_n != state) |=> (state == DEAD));

endmodule

// File: rtl/pwm_deadtime_gate.sv
// Gate-drive stage: edge-aligned high-side PWM (H-PWM / L-ON), per-leg dead time
// and a sticky shoot-through request flag.
module pwm_deadtime_gate
  import bldc_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned DT_W  = 6
) (
  input logic               clk,
  input logic               rst,
  pwm_deadtime_gate_if.slave bus
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  duty_q;
  logic              pwm_on;
  logic              sync_q;
  logic              flt_q;
  logic [N_LEGS-1:0] req_h, req_l, g_h, g_l, viol;
  logic [5:0]        g;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      duty_q <= '0;
      sync_q <= 1'b0;
      flt_q  <= 1'b0;
    end else begin
      cnt    <= cnt + 1'b1;
      sync_q <= (cnt == '1);
      if (cnt == '1) begin
        duty_q <= bus.duty;
      end
      if (|viol) begin
        flt_q <= 1'b1;
      end else if (bus.clr_flt) begin
        flt_q <= 1'b0;
      end
    end
  end

  assign pwm_on = (cnt < duty_q);

  for (genvar k = 0; k < N_LEGS; k++) begin : g_leg
    localparam int unsigned HB = AH - 2 * k;
    localparam int unsigned LB = AL - 2 * k;

    // A raw H+L request must reach the leg as a conflict even during the PWM
    // off-phase, so the PWM gate is bypassed whenever the low side is also requested.
    assign req_h[k] = bus.en & bus.PT[HB] & (pwm_on | bus.PT[LB]);
    assign req_l[k] = bus.en & bus.PT[LB];

    deadtime_leg #(
      .DT_W(DT_W)
    ) u_leg (
      .clk (clk),
      .rst (rst),
      .reqH(req_h[k]),
      .reqL(req_l[k]),
      .dead(bus.dead),
      .gH  (g_h[k]),
      .gL  (g_l[k]),
      .viol(viol[k])
    );
  end

  always_comb begin
    g     = '0;
    g[AH] = g_h[0];
    g[AL] = g_l[0];
    g[BH] = g_h[1];
    g[BL] = g_l[1];
    g[CH] = g_h[2];
    g[CL] = g_l[2];
  end

  assign bus.G        = g;
  assign bus.pwm_sync = sync_q;
  assign bus.flt      = flt_q;

  a_no_shoot_through: assert property (@(posedge clk) disable iff (rst)
    !(g[AH] && g[AL]) && !(g[BH] && g[BL]) && !(g[CH] && g[CL]));

  a_flt_sets: assert property (@(posedge clk) disable iff (rst) (|viol) |=> flt_q);

endmodule

// File: tb/tb_pwm_deadtime_gate.sv
// Bench for pwm_deadtime_gate: vector table, directed timing sequences and random
// stimulus, all checked against a timestamp-based behavioural model.
module tb_pwm_deadtime_gate;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DT_W  = 6;
  localparam int          P     = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_deadtime_gate_if #(.CNT_W(CNT_W), .DT_W(DT_W)) bus ();

  pwm_deadtime_gate #(.CNT_W(CNT_W), .DT_W(DT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: cycle count since reset, latched duty, and per leg the conducting
  // switch (0 none, 1 high, 2 low) plus the cycle at which it may next decide.
  int t;
  int m_duty;
  int m_cond [3];
  int m_dec  [3];
  bit m_flt;
  bit m_sync;

  typedef struct {
    logic       en;
    logic [5:0] pt;
    logic       clr;
    int         hold;
    logic [5:0] g;
    logic       flt;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] model_g();
    logic [5:0] r;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      r[5-2*k] = (m_cond[k] == 1);
      r[4-2*k] = (m_cond[k] == 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    t      = 0;
    m_duty = 0;
    m_flt  = 1'b0;
    m_sync = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_cond[k] = 0;
      m_dec[k]  = 0;
    end
  endtask

  task automatic model_step();
    int cnt;
    bit pwm_on;
    bit vio;
    bit h, l;
    int tg;
    cnt    = t % P;
    pwm_on = (cnt < m_duty);
    vio    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      h = bus.PT[5-2*k];
      l = bus.PT[4-2*k];
      if (bus.en && h && l) begin
        tg  = 0;
        vio = 1'b1;
      end else if (bus.en && h && pwm_on) tg = 1;
      else if (bus.en && l) tg = 2;
      else tg = 0;
      if (m_cond[k] != 0) begin
        if (tg != m_cond[k]) begin
          m_cond[k] = 0;
          m_dec[k]  = t + int'(bus.dead) + 1;
        end
      end else if (t >= m_dec[k]) begin
        m_cond[k] = tg;
      end
    end
    if (vio) m_flt = 1'b1;
    else if (bus.clr_flt) m_flt = 1'b0;
    m_sync = (cnt == P - 1);
    if (cnt == P - 1) m_duty = int'(bus.duty);
    t++;
  endtask

  task automatic tick();
    if (rst) model_reset();
    else model_step();
    @(posedge clk);
    #1;
    check("G", bus.G, model_g());
    check("flt", bus.flt, m_flt);
    check("pwm_sync", bus.pwm_sync, m_sync);
  endtask

  task automatic wait_sync();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.pwm_sync !== 1'b1 && n < P + 4);
    if (bus.pwm_sync !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL sync_wait: no pwm_sync within %0d cycles", P + 4);
    end
  endtask

  initial begin
    int highs;
    int first;
    int g0;
    int n;
    logic [5:0] p;

    tbl[0]  = '{1'b1, 6'b010101, 1'b0, 4, 6'b010101, 1'b0};
    tbl[1]  = '{1'b1, 6'b000000, 1'b0, 6, 6'b000000, 1'b0};
    tbl[2]  = '{1'b1, 6'b110000, 1'b0, 1, 6'b000000, 1'b1};
    tbl[3]  = '{1'b1, 6'b000000, 1'b1, 1, 6'b000000, 1'b0};
    tbl[4]  = '{1'b1, 6'b110000, 1'b1, 1, 6'b000000, 1'b1};
    tbl[5]  = '{1'b1, 6'b000000, 1'b1, 1, 6'b000000, 1'b0};
    tbl[6]  = '{1'b1, 6'b101010, 1'b0, 4, 6'b000000, 1'b0};
    tbl[7]  = '{1'b0, 6'b011001, 1'b0, 4, 6'b000000, 1'b0};
    tbl[8]  = '{1'b1, 6'b011001, 1'b0, 6, 6'b010001, 1'b0};
    tbl[9]  = '{1'b1, 6'b001100, 1'b0, 6, 6'b000000, 1'b1};
    tbl[10] = '{1'b1, 6'b000000, 1'b1, 1, 6'b000000, 1'b0};

    rst         = 1'b1;
    bus.en      = 1'b1;
    bus.PT      = 6'b111111;
    bus.duty    = '0;
    bus.dead    = '0;
    bus.clr_flt = 1'b0;
    model_reset();
    repeat (3) tick();
    check("rst_G", bus.G, 6'b000000);
    check("rst_flt", bus.flt, 1'b0);

    // Vector table; duty stays 0 so only low sides and the fault logic act.
    bus.dead = 6'd2;
    rst      = 1'b0;
    for (int i = 0; i < NV; i++) begin
      bus.en      = tbl[i].en;
      bus.PT      = tbl[i].pt;
      bus.clr_flt = tbl[i].clr;
      repeat (tbl[i].hold) tick();
      check($sformatf("vec%0d_G", i), bus.G, tbl[i].g);
      check($sformatf("vec%0d_flt", i), bus.flt, tbl[i].flt);
    end
    bus.clr_flt = 1'b0;

    // 50% PWM with low side on: 128 on, 128 off, rise one cycle after sync.
    bus.duty = 8'd128;
    bus.dead = 6'd3;
    bus.PT   = 6'b100001;
    wait_sync();
    highs = 0;
    first = -1;
    g0    = 0;
    for (int i = 0; i < P; i++) begin
      if (bus.G[5]) begin
        highs++;
        if (first < 0) first = i;
      end
      if (bus.G[0]) g0++;
      tick();
    end
    check("A_high_cnt", highs, 128);
    check("A_rise_off", first, 1);
    check("A_g0_on", g0, 256);
    check("A_sync_period", bus.pwm_sync, 1'b1);

    // Commutation 100001 -> 011000 with dead=5.
    bus.duty = 8'd255;
    bus.dead = 6'd5;
    wait_sync();
    repeat (10) tick();
    check("B_pre", bus.G, 6'b100001);
    bus.PT = 6'b011000;
    tick();
    check("B_fall", bus.G, 6'b001000);
    n = 0;
    while (bus.G[4] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("B_low_delay", n, 6);
    check("B_post", bus.G, 6'b011000);

    // Duty update takes effect only at the next period.
    bus.duty = 8'd50;
    bus.dead = 6'd0;
    bus.PT   = 6'b100000;
    wait_sync();
    highs = 0;
    for (int i = 0; i < P; i++) begin
      if (i == 10) bus.duty = 8'd200;
      if (bus.G[5]) highs++;
      tick();
    end
    check("C_period50", highs, 50);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      if (i == 0) bus.duty = 8'd0;
      if (bus.G[5]) highs++;
      tick();
    end
    check("C_period200", highs, 200);
    highs = 0;
    for (int i = 0; i < P; i++) begin
      if (bus.G[5]) highs++;
      tick();
    end
    check("C_period0", highs, 0);

    // Enable drop, async reset while conducting and while in dead time.
    bus.duty = 8'd255;
    bus.dead = 6'd3;
    bus.PT   = 6'b100001;
    wait_sync();
    repeat (10) tick();
    check("D_pre", bus.G, 6'b100001);
    bus.en = 1'b0;
    tick();
    check("D_en_off", bus.G, 6'b000000);
    repeat (5) tick();
    check("D_en_hold", bus.G, 6'b000000);
    bus.en = 1'b1;
    repeat (10) tick();
    check("D_en_on", bus.G, 6'b100001);
    #2 rst = 1'b1;
    #1 check("D_async_rst", bus.G, 6'b000000);
    tick();
    tick();
    rst      = 1'b0;
    bus.dead = 6'd20;
    bus.PT   = 6'b010000;
    repeat (3) tick();
    check("D_low_on", bus.G, 6'b010000);
    bus.PT = 6'b000000;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1 check("D_rst_in_dead", bus.G, 6'b000000);
    tick();
    rst    = 1'b0;
    bus.PT = 6'b010000;
    tick();
    check("D_off_after_rst", bus.G, 6'b010000);

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) begin
        p = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 15) != 0) begin
          for (int k = 0; k < 3; k++) begin
            if (p[5-2*k] && p[4-2*k]) p[4-2*k] = 1'b0;
          end
        end
        bus.PT = p;
      end
      if ($urandom_range(0, 49) == 0) begin
        case ($urandom_range(0, 3))
          0:       bus.duty = 8'd0;
          1:       bus.duty = 8'd255;
          default: bus.duty = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 99) == 0) bus.dead = 6'($urandom_range(0, 9));
      if ($urandom_range(0, 149) == 0) bus.en = ~bus.en;
      bus.clr_flt = ($urandom_range(0, 39) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
